// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared fetch widths, reset PC, NOP encoding, FSM states and entry type
package rv_pkg;

   localparam int              XLEN      = 32;
   localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      DRAIN
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            misaligned;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous fetch FIFO with push, pop, flush and occupancy outputs
module fetch_fifo
   import rv_pkg::*;
#(
   parameter int  DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fetch_entry_t  wr_entry,
   output fetch_entry_t  rd_entry,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign rd_entry = mem_q[rd_ptr_q];
   assign do_pop   = pop && !empty;
   // A push into a full FIFO is only taken when the head leaves in the same cycle
   assign do_push  = push && (!full || do_pop);

   // Next storage/pointer/count; flush discards every entry
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wr_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // FIFO state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage; FETCH_MISALIGN_CHECK_EN adds the misaligned-PC trap entry
module fetch_unit #(
   parameter int              XLEN      = rv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = rv_pkg::RESET_PC,
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_next,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic            if_misaligned
`endif
);

   import rv_pkg::*;

   localparam int CW = $clog2(BUF_DEPTH + 1);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_inflight_q, pc_inflight_d;
   logic            outstanding;
   logic            slot_free;
   logic            pc_bad;
   logic            req_valid_int;
   logic            req_fire;
   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   fetch_entry_t    push_entry;
   fetch_entry_t    head_entry;
   logic            unused_bits;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic            mis_done_q, mis_done_d;
   assign pc_bad        = (pc[1:0] != 2'b00);
   assign if_misaligned = head_entry.misaligned;
   assign unused_bits   = fifo_full;
`else
   assign pc_bad        = 1'b0;
   assign unused_bits   = fifo_full ^ head_entry.misaligned;
`endif

   // A request always has a FIFO slot reserved, counting the one in flight
   assign outstanding   = (state_q != REQ);
   assign slot_free     = (int'(fifo_count) + int'(outstanding)) < BUF_DEPTH;
   assign req_valid_int = (state_q == REQ) && slot_free && !redirect_valid && !pc_bad;
   assign req_fire      = req_valid_int && imem_req_ready;

   assign imem_req_valid = req_valid_int && !rst;
   assign imem_addr      = pc;
   assign fifo_pop       = if_valid && if_ready;
   assign if_valid       = !fifo_empty;
   assign if_pc          = head_entry.pc;
   assign if_instr       = head_entry.instr;

   // Next PC: redirect wins, then a taken request advances, otherwise hold
   always_comb begin
      pc_next = pc;
      if (rst) begin
         pc_next = RESET_PC;
      end else if (redirect_valid) begin
         pc_next = redirect_pc;
      end else if (req_fire) begin
         pc_next = pc + XLEN'(4);
      end
   end

   // Fetch FSM next state, FIFO push and in-flight PC capture
   always_comb begin
      state_d       = state_q;
      pc_inflight_d = pc_inflight_q;
      fifo_push     = 1'b0;
      push_entry    = '{pc: pc_inflight_q, instr: imem_rsp_data, misaligned: 1'b0};
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_done_d    = mis_done_q && !redirect_valid;
`endif
      case (state_q)
         REQ: begin
            if (req_fire) begin
               state_d       = WAIT;
               pc_inflight_d = pc;
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            else if (slot_free && !redirect_valid && pc_bad && !mis_done_q) begin
               fifo_push  = 1'b1;
               push_entry = '{pc: pc, instr: NOP_INSTR, misaligned: 1'b1};
               mis_done_d = 1'b1;
            end
`endif
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               // A response landing with a redirect is stale and dropped
               fifo_push = !redirect_valid;
               state_d   = REQ;
            end else if (redirect_valid) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (imem_rsp_valid) begin
               state_d = REQ;
            end
         end
         default: state_d = REQ;
      endcase
   end

   // FSM and in-flight PC registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= REQ;
         pc_inflight_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_inflight_q <= pc_inflight_d;
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   // Misaligned trap entry is produced once per redirect target
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mis_done_q <= 1'b0;
      end else begin
         mis_done_q <= mis_done_d;
      end
   end
`endif

   fetch_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push),
      .pop      (fifo_pop),
      .flush    (redirect_valid),
      .wr_entry (push_entry),
      .rd_entry (head_entry),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized self-checking bench for fetch_unit
`timescale 1ns/1ps
module tb_fetch_unit;

   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        if_misaligned;
`endif

   always #5 clk = ~clk;

   fetch_unit #(
      .XLEN      (32),
      .RESET_PC  (RST_PC),
      .BUF_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pc             (pc),
      .pc_next        (pc_next),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .if_misaligned  (if_misaligned)
`endif
   );

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   // reference model: program-order expectations and fetched-but-undecoded count
   logic [31:0] exp_fetch;
   logic [31:0] exp_dec;
   int          occ;
   bit          in_flight;
   bit          discard;
   bit          model_en;
   // memory model
   bit          mem_busy;
   int          mem_wait;
   logic [31:0] mem_addr;
   int          lat_min;
   int          lat_max;
   int          hs_count;
   logic [31:0] last_hs_addr;
   int          first_hs_cyc;
   int          first_val_cyc;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: memory responds, outputs are checked mid-cycle, PC register updates
   task automatic tick();
      logic [31:0] pcn;
      bit          hs;
      bit          pop;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (mem_busy) begin
         mem_wait--;
         if (mem_wait == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_f(mem_addr);
            mem_busy       = 1'b0;
         end
      end
      #1;
      hs  = imem_req_valid && imem_req_ready;
      pop = if_valid && if_ready;
      if (rst) begin
         chk("rst_pc_next", pc_next, RST_PC);
         chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
         chk("rst_if_valid", 32'(if_valid), 32'd0);
         occ       = 0;
         in_flight = 1'b0;
         discard   = 1'b0;
         exp_fetch = RST_PC;
         exp_dec   = RST_PC;
      end else if (model_en) begin
         chk("req_valid", 32'(imem_req_valid), 32'(!in_flight && occ < DEPTH && !redirect_valid));
         chk("if_valid", 32'(if_valid), 32'(occ != 0));
         chk("pc_next", pc_next, redirect_valid ? redirect_pc : (hs ? pc + 32'd4 : pc));
         chk("imem_addr_eq_pc", imem_addr, pc);
         if (hs) begin
            chk("fetch_addr", imem_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
         end
         if (pop) begin
            chk("if_pc", if_pc, exp_dec);
            chk("if_instr", if_instr, mem_f(exp_dec));
            exp_dec = exp_dec + 32'd4;
         end
         if (imem_rsp_valid && in_flight) begin
            if (!discard && !redirect_valid) occ++;
            in_flight = 1'b0;
            discard   = 1'b0;
         end
         if (pop) occ--;
         if (redirect_valid) begin
            occ       = 0;
            discard   = in_flight;
            exp_fetch = redirect_pc;
            exp_dec   = redirect_pc;
         end
         if (hs) in_flight = 1'b1;
      end
      if (hs) begin
         mem_busy     = 1'b1;
         mem_addr     = imem_addr;
         mem_wait     = $urandom_range(lat_max, lat_min);
         hs_count++;
         last_hs_addr = imem_addr;
         if (first_hs_cyc < 0) first_hs_cyc = cyc;
      end
      if (if_valid && first_val_cyc < 0) first_val_cyc = cyc;
      pcn = pc_next;
      @(posedge clk);
      #1;
      pc = pcn;
      cyc++;
      @(negedge clk);
   endtask

   // Reset, then let any stale response drain with requests held off
   task automatic do_reset();
      rst            = 1'b1;
      imem_req_ready = 1'b0;
      redirect_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10 && mem_busy; i++) tick();
      chk("reset_mem_idle", 32'(mem_busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] pc0;
      int          hs0;
      rst            = 1'b1;
      pc             = RST_PC;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      if_ready       = 1'b0;
      model_en       = 1'b1;
      mem_busy       = 1'b0;
      mem_wait       = 0;
      mem_addr       = '0;
      lat_min        = 1;
      lat_max        = 1;
      hs_count       = 0;
      last_hs_addr   = '1;
      first_hs_cyc   = -1;
      first_val_cyc  = -1;
      occ            = 0;
      in_flight      = 1'b0;
      discard        = 1'b0;
      exp_fetch      = RST_PC;
      exp_dec        = RST_PC;
      @(negedge clk);

      // streaming with 1-cycle memory and free decode
      do_reset();
      first_hs_cyc   = -1;
      first_val_cyc  = -1;
      imem_req_ready = 1'b1;
      if_ready       = 1'b1;
      repeat (8) tick();
      chk("first_latency", 32'(first_val_cyc - first_hs_cyc), 32'd2);

      // decode stalled: FIFO fills after two fetches, PC holds at 8
      do_reset();
      imem_req_ready = 1'b1;
      if_ready       = 1'b0;
      repeat (10) tick();
      chk("stall_pc", pc, 32'd8);
      chk("stall_pc_next", pc_next, 32'd8);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall_if_valid", 32'(if_valid), 32'd1);
      chk("stall_if_pc", if_pc, 32'd0);
      if_ready = 1'b1;

      // redirect to 100 while waiting for the response at 12
      lat_min      = 3;
      lat_max      = 3;
      last_hs_addr = '1;
      for (int i = 0; i < 40 && last_hs_addr != 32'd12; i++) tick();
      chk("reach_fetch_12", last_hs_addr, 32'd12);
      redirect_valid = 1'b1;
      redirect_pc    = 32'd100;
      tick();
      redirect_valid = 1'b0;
      repeat (12) tick();
      chk("after_redirect_hs", 32'(last_hs_addr >= 32'd100), 32'd1);

      // memory not ready for three cycles
      lat_min = 1;
      lat_max = 1;
      repeat (3) tick();
      imem_req_ready = 1'b0;
      pc0 = pc;
      repeat (3) tick();
      chk("ready_low_pc_hold", pc, pc0);
      imem_req_ready = 1'b1;
      repeat (4) tick();

      // reset while a request is outstanding; its response arrives afterwards
      lat_min = 3;
      lat_max = 3;
      hs0 = hs_count;
      for (int i = 0; i < 20 && hs_count == hs0; i++) tick();
      chk("mid_reset_hs_seen", 32'(hs_count != hs0), 32'd1);
      rst = 1'b1;
      tick();
      tick();
      rst            = 1'b0;
      imem_req_ready = 1'b0;
      for (int i = 0; i < 10 && mem_busy; i++) tick();
      repeat (3) tick();
      chk("stale_not_pushed", 32'(if_valid), 32'd0);
      lat_min        = 1;
      lat_max        = 1;
      imem_req_ready = 1'b1;
      hs0 = hs_count;
      tick();
      chk("post_reset_hs", 32'(hs_count - hs0), 32'd1);
      chk("post_reset_addr", last_hs_addr, RST_PC);

      // randomized traffic with redirects
      lat_min = 1;
      lat_max = 3;
      for (int i = 0; i < 800; i++) begin
         imem_req_ready = ($urandom_range(3, 0) != 0);
         if_ready       = ($urandom_range(9, 0) < 6);
         redirect_valid = ($urandom_range(39, 0) == 0);
         redirect_pc    = $urandom & 32'hFFFF_FFFC;
         tick();
      end
      redirect_valid = 1'b0;

`ifdef FETCH_MISALIGN_CHECK_EN
      // misaligned redirect target produces a NOP trap entry and no fetch
      model_en       = 1'b0;
      if_ready       = 1'b0;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'd102;
      tick();
      redirect_valid = 1'b0;
      hs0 = hs_count;
      repeat (8) tick();
      chk("mis_no_request", 32'(hs_count - hs0), 32'd0);
      chk("mis_pc_hold", pc, 32'd102);
      chk("mis_pc_next", pc_next, 32'd102);
      chk("mis_if_valid", 32'(if_valid), 32'd1);
      chk("mis_flag", 32'(if_misaligned), 32'd1);
      chk("mis_instr", if_instr, 32'h0000_0013);
      chk("mis_if_pc", if_pc, 32'd102);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
